// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller around a prescaled up-counter.
//
// Purpose:
//   The host loads a terminal count, a prescale divisor and a mode through a
//   valid/ready config handshake. The block then runs the counter through
//   load, run, hold and terminal-count events.
//
// Ports:
//   CLK           clock, rising edge
//   RESET_N       asynchronous active-low reset
//   vccd1/vssd1   power pins (only when USE_POWER_PINS is defined)
//   CFG_VALID     config offer
//   CFG_READY     config can be accepted (low only in RUN)
//   CFG_LIMIT     terminal count
//   CFG_PRESCALE  tick every CFG_PRESCALE+1 cycles
//   CFG_PERIODIC  1 = auto-restart, 0 = one-shot
//   START         begin/resume counting
//   STOP          pause counting
//   C             current count
//   BUSY          state is RUN
//   DONE          one-cycle pulse after the terminal edge
//   IRQ_CLR/IRQ   sticky DONE flag and its clear
//                 (only when COUNTER_SEQUENCER_IRQ_EN is defined)
//
// Optional feature macro: COUNTER_SEQUENCER_IRQ_EN
module counter_sequencer #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
`ifdef USE_POWER_PINS
   inout  wire                    vccd1,
   inout  wire                    vssd1,
`endif
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   CFG_VALID,
   output logic                   CFG_READY,
   input  logic [WIDTH-1:0]       CFG_LIMIT,
   input  logic [PRESCALE_W-1:0]  CFG_PRESCALE,
   input  logic                   CFG_PERIODIC,
   input  logic                   START,
   input  logic                   STOP,
`ifdef COUNTER_SEQUENCER_IRQ_EN
   input  logic                   IRQ_CLR,
   output logic                   IRQ,
`endif
   output logic [WIDTH-1:0]       C,
   output logic                   BUSY,
   output logic                   DONE
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOADED,
      S_RUN,
      S_HOLD
   } state_t;

   state_t                 state, state_n;
   logic [WIDTH-1:0]       cnt, cnt_n;
   logic [PRESCALE_W-1:0]  ps, ps_n;
   logic [WIDTH-1:0]       limit_q, limit_n;
   logic [PRESCALE_W-1:0]  pre_q, pre_n;
   logic                   per_q, per_n;
   logic                   done_q, done_n;
   logic                   busy_q;
   logic                   cfg_xfer;

   assign CFG_READY = (state != S_RUN);
   assign cfg_xfer  = CFG_VALID && CFG_READY;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= S_IDLE;
         cnt     <= '0;
         ps      <= '0;
         limit_q <= '0;
         pre_q   <= '0;
         per_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ps      <= ps_n;
         limit_q <= limit_n;
         pre_q   <= pre_n;
         per_q   <= per_n;
         done_q  <= done_n;
         busy_q  <= (state_n == S_RUN);
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ps_n    = ps;
      limit_n = limit_q;
      pre_n   = pre_q;
      per_n   = per_q;
      done_n  = 1'b0;
      // A config transfer overrides any coincident START.
      if (cfg_xfer) begin
         limit_n = CFG_LIMIT;
         pre_n   = CFG_PRESCALE;
         per_n   = CFG_PERIODIC;
         cnt_n   = '0;
         ps_n    = '0;
         state_n = S_LOADED;
      end else begin
         unique case (state)
            S_IDLE: ;
            S_LOADED,
            S_HOLD: begin
               if (START) state_n = S_RUN;
            end
            S_RUN: begin
               // STOP freezes everything, even a terminal tick.
               if (STOP) begin
                  state_n = S_HOLD;
               end else if (ps == pre_q) begin
                  ps_n = '0;
                  if (cnt == limit_q) begin
                     cnt_n  = '0;
                     done_n = 1'b1;
                     if (!per_q) state_n = S_LOADED;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  ps_n = ps + 1'b1;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   assign C    = cnt;
   assign BUSY = busy_q;
   assign DONE = done_q;

`ifdef COUNTER_SEQUENCER_IRQ_EN
   logic irq_q;

   // Set has priority over a simultaneous clear.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)     irq_q <= 1'b0;
      else if (done_q)  irq_q <= 1'b1;
      else if (IRQ_CLR) irq_q <= 1'b0;
   end

   assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed self-checking bench for counter_sequencer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_counter_sequencer;

   localparam int W  = 8;
   localparam int PW = 4;

   logic          CLK;
   logic          RESET_N;
   logic          CFG_VALID;
   logic          CFG_READY;
   logic [W-1:0]  CFG_LIMIT;
   logic [PW-1:0] CFG_PRESCALE;
   logic          CFG_PERIODIC;
   logic          START;
   logic          STOP;
   logic [W-1:0]  C;
   logic          BUSY;
   logic          DONE;
`ifdef COUNTER_SEQUENCER_IRQ_EN
   logic          IRQ_CLR;
   logic          IRQ;
`endif
`ifdef USE_POWER_PINS
   wire vccd1 = 1'b1;
   wire vssd1 = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   counter_sequencer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
`ifdef USE_POWER_PINS
      .vccd1        (vccd1),
      .vssd1        (vssd1),
`endif
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .CFG_VALID    (CFG_VALID),
      .CFG_READY    (CFG_READY),
      .CFG_LIMIT    (CFG_LIMIT),
      .CFG_PRESCALE (CFG_PRESCALE),
      .CFG_PERIODIC (CFG_PERIODIC),
      .START        (START),
      .STOP         (STOP),
`ifdef COUNTER_SEQUENCER_IRQ_EN
      .IRQ_CLR      (IRQ_CLR),
      .IRQ          (IRQ),
`endif
      .C            (C),
      .BUSY         (BUSY),
      .DONE         (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [W-1:0] lim,
                       input logic [PW-1:0] pre,
                       input logic per);
      CFG_VALID    = 1'b1;
      CFG_LIMIT    = lim;
      CFG_PRESCALE = pre;
      CFG_PERIODIC = per;
      step();
      CFG_VALID = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (C !== 8'd0) begin
         n_errors++; $display("FAIL rst_c: got %0d want 0", C);
      end
      n_checks++;
      if (BUSY !== 1'b0) begin
         n_errors++; $display("FAIL rst_busy: got %b want 0", BUSY);
      end
      n_checks++;
      if (DONE !== 1'b0) begin
         n_errors++; $display("FAIL rst_done: got %b want 0", DONE);
      end
      n_checks++;
      if (CFG_READY !== 1'b1) begin
         n_errors++; $display("FAIL rst_ready: got %b want 1", CFG_READY);
      end
      // START in IDLE must do nothing.
      START = 1'b1;
      step();
      step();
      START = 1'b0;
      n_checks++;
      if (BUSY !== 1'b0) begin
         n_errors++; $display("FAIL idle_start: busy %b want 0", BUSY);
      end
   endtask

   task automatic test_reset_midrun();
      load(8'd5, 4'd0, 1'b0);
      START = 1'b1;
      step();
      START = 1'b0;
      for (int i = 0; i < 3; i++) step();
      n_checks++;
      if (C !== 8'd3) begin
         n_errors++; $display("FAIL mid_c3: got %0d want 3", C);
      end
      RESET_N = 1'b0;
      #1;
      n_checks++;
      if (C !== 8'd0) begin
         n_errors++; $display("FAIL mid_rst_c: got %0d want 0", C);
      end
      n_checks++;
      if (BUSY !== 1'b0) begin
         n_errors++; $display("FAIL mid_rst_busy: got %b want 0", BUSY);
      end
      n_checks++;
      if (CFG_READY !== 1'b1) begin
         n_errors++; $display("FAIL mid_rst_rdy: got %b want 1", CFG_READY);
      end
      step();
      RESET_N = 1'b1;
      START = 1'b1;
      step();
      step();
      START = 1'b0;
      n_checks++;
      if (BUSY !== 1'b0 || C !== 8'd0) begin
         n_errors++;
         $display("FAIL mid_idle: busy %b c %0d want 0 0", BUSY, C);
      end
   endtask

   task automatic test_oneshot();
      load(8'd3, 4'd0, 1'b0);
      n_checks++;
      if (C !== 8'd0 || BUSY !== 1'b0 || CFG_READY !== 1'b1) begin
         n_errors++;
         $display("FAIL os_loaded: c %0d busy %b rdy %b want 0 0 1",
                  C, BUSY, CFG_READY);
      end
      START = 1'b1;
      step();
      START = 1'b0;
      n_checks++;
      if (BUSY !== 1'b1 || C !== 8'd0 || CFG_READY !== 1'b0) begin
         n_errors++;
         $display("FAIL os_run: busy %b c %0d rdy %b want 1 0 0",
                  BUSY, C, CFG_READY);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         n_checks++;
         if (C !== W'(i) || DONE !== 1'b0 || BUSY !== 1'b1) begin
            n_errors++;
            $display("FAIL os_cnt%0d: c %0d done %b busy %b want %0d 0 1",
                     i, C, DONE, BUSY, i);
         end
      end
      step();
      n_checks++;
      if (C !== 8'd0 || DONE !== 1'b1 || BUSY !== 1'b0) begin
         n_errors++;
         $display("FAIL os_term: c %0d done %b busy %b want 0 1 0",
                  C, DONE, BUSY);
      end
      step();
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || CFG_READY !== 1'b1) begin
         n_errors++;
         $display("FAIL os_after: done %b busy %b rdy %b want 0 0 1",
                  DONE, BUSY, CFG_READY);
      end
   endtask

   task automatic test_periodic();
      logic [W-1:0] ec;
      logic         ed;
      load(8'd2, 4'd2, 1'b1);
      START = 1'b1;
      step();
      START = 1'b0;
      for (int k = 1; k <= 27; k++) begin
         step();
         ec = W'((k / 3) % 3);
         ed = (k % 9 == 0);
         n_checks++;
         if (C !== ec || DONE !== ed || BUSY !== 1'b1) begin
            n_errors++;
            $display("FAIL per_k%0d: c %0d done %b busy %b want %0d %b 1",
                     k, C, DONE, BUSY, ec, ed);
         end
      end
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      n_checks++;
      if (BUSY !== 1'b0 || CFG_READY !== 1'b1) begin
         n_errors++;
         $display("FAIL per_stop: busy %b rdy %b want 0 1", BUSY, CFG_READY);
      end
   endtask

   task automatic test_stop_collision();
      load(8'd2, 4'd0, 1'b0);
      START = 1'b1;
      step();
      START = 1'b0;
      step();
      step();
      n_checks++;
      if (C !== 8'd2) begin
         n_errors++; $display("FAIL col_pre: got %0d want 2", C);
      end
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      n_checks++;
      if (C !== 8'd2 || DONE !== 1'b0 || BUSY !== 1'b0) begin
         n_errors++;
         $display("FAIL col_hold: c %0d done %b busy %b want 2 0 0",
                  C, DONE, BUSY);
      end
      step();
      n_checks++;
      if (C !== 8'd2 || DONE !== 1'b0) begin
         n_errors++;
         $display("FAIL col_frozen: c %0d done %b want 2 0", C, DONE);
      end
      START = 1'b1;
      step();
      START = 1'b0;
      n_checks++;
      if (C !== 8'd2 || BUSY !== 1'b1) begin
         n_errors++;
         $display("FAIL col_resume: c %0d busy %b want 2 1", C, BUSY);
      end
      step();
      n_checks++;
      if (C !== 8'd0 || DONE !== 1'b1 || BUSY !== 1'b0) begin
         n_errors++;
         $display("FAIL col_term: c %0d done %b busy %b want 0 1 0",
                  C, DONE, BUSY);
      end
   endtask

   task automatic test_config_rules();
      load(8'd4, 4'd0, 1'b1);
      START = 1'b1;
      step();
      START = 1'b0;
      // Offer a different limit while running: must be ignored.
      CFG_VALID = 1'b1;
      CFG_LIMIT = 8'd1;
      CFG_PERIODIC = 1'b0;
      n_checks++;
      if (CFG_READY !== 1'b0) begin
         n_errors++; $display("FAIL cfg_rdy_run: got %b want 0", CFG_READY);
      end
      step();
      step();
      CFG_VALID = 1'b0;
      n_checks++;
      if (C !== 8'd2 || BUSY !== 1'b1) begin
         n_errors++;
         $display("FAIL cfg_ignored: c %0d busy %b want 2 1", C, BUSY);
      end
      step();
      step();
      step();
      n_checks++;
      if (C !== 8'd0 || DONE !== 1'b1 || BUSY !== 1'b1) begin
         n_errors++;
         $display("FAIL cfg_oldlim: c %0d done %b busy %b want 0 1 1",
                  C, DONE, BUSY);
      end
      step();
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      n_checks++;
      if (C !== 8'd1 || BUSY !== 1'b0 || CFG_READY !== 1'b1) begin
         n_errors++;
         $display("FAIL cfg_hold: c %0d busy %b rdy %b want 1 0 1",
                  C, BUSY, CFG_READY);
      end
      // Config and START together: config wins.
      CFG_VALID = 1'b1;
      CFG_LIMIT = 8'd2;
      CFG_PRESCALE = 4'd0;
      CFG_PERIODIC = 1'b0;
      START = 1'b1;
      step();
      CFG_VALID = 1'b0;
      START = 1'b0;
      n_checks++;
      if (C !== 8'd0 || BUSY !== 1'b0) begin
         n_errors++;
         $display("FAIL cfg_win: c %0d busy %b want 0 0", C, BUSY);
      end
      step();
      n_checks++;
      if (BUSY !== 1'b0 || C !== 8'd0) begin
         n_errors++;
         $display("FAIL cfg_loaded: busy %b c %0d want 0 0", BUSY, C);
      end
      START = 1'b1;
      step();
      START = 1'b0;
      step();
      step();
      n_checks++;
      if (C !== 8'd2 || DONE !== 1'b0) begin
         n_errors++;
         $display("FAIL cfg_newlim: c %0d done %b want 2 0", C, DONE);
      end
      step();
      n_checks++;
      if (C !== 8'd0 || DONE !== 1'b1 || BUSY !== 1'b0) begin
         n_errors++;
         $display("FAIL cfg_newterm: c %0d done %b busy %b want 0 1 0",
                  C, DONE, BUSY);
      end
   endtask

   task automatic test_limit_max();
      load(8'd255, 4'd0, 1'b1);
      START = 1'b1;
      step();
      START = 1'b0;
      for (int i = 0; i < 255; i++) step();
      n_checks++;
      if (C !== 8'd255 || DONE !== 1'b0) begin
         n_errors++;
         $display("FAIL max_top: c %0d done %b want 255 0", C, DONE);
      end
      step();
      n_checks++;
      if (C !== 8'd0 || DONE !== 1'b1 || BUSY !== 1'b1) begin
         n_errors++;
         $display("FAIL max_wrap: c %0d done %b busy %b want 0 1 1",
                  C, DONE, BUSY);
      end
      STOP = 1'b1;
      step();
      STOP = 1'b0;
   endtask

`ifdef COUNTER_SEQUENCER_IRQ_EN
   task automatic test_irq();
      load(8'd0, 4'd1, 1'b1);
      START = 1'b1;
      step();
      START = 1'b0;
      step();
      step();
      n_checks++;
      if (DONE !== 1'b1 || IRQ !== 1'b0 || C !== 8'd0) begin
         n_errors++;
         $display("FAIL irq_d1: done %b irq %b c %0d want 1 0 0",
                  DONE, IRQ, C);
      end
      step();
      n_checks++;
      if (IRQ !== 1'b1 || DONE !== 1'b0) begin
         n_errors++;
         $display("FAIL irq_set: irq %b done %b want 1 0", IRQ, DONE);
      end
      step();
      IRQ_CLR = 1'b1;
      step();
      n_checks++;
      if (IRQ !== 1'b1) begin
         n_errors++; $display("FAIL irq_setwins: got %b want 1", IRQ);
      end
      step();
      IRQ_CLR = 1'b0;
      n_checks++;
      if (IRQ !== 1'b0 || DONE !== 1'b1) begin
         n_errors++;
         $display("FAIL irq_clr: irq %b done %b want 0 1", IRQ, DONE);
      end
      STOP = 1'b1;
      step();
      STOP = 1'b0;
   endtask
`endif

   initial begin
      RESET_N      = 1'b0;
      CFG_VALID    = 1'b0;
      CFG_LIMIT    = '0;
      CFG_PRESCALE = '0;
      CFG_PERIODIC = 1'b0;
      START        = 1'b0;
      STOP         = 1'b0;
`ifdef COUNTER_SEQUENCER_IRQ_EN
      IRQ_CLR      = 1'b0;
`endif
      step();
      step();
      test_reset();
      RESET_N = 1'b1;
      step();
      test_reset();
      test_reset_midrun();
      test_oneshot();
      test_periodic();
      test_stop_collision();
      test_config_rules();
      test_limit_max();
`ifdef COUNTER_SEQUENCER_IRQ_EN
      test_irq();
`endif
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
